hpb_wr_ctl: RTL

HPB_WR_CTL -- requirements
Module: hpb_wr_ctl

---
 rtl/tts_pkg.sv | 11 +
 rtl/hpb_fifo.sv | 52 +++++
 rtl/hpb_wr_ctl.sv | 112 +++++++++++
 3 files changed

// File: rtl/tts_pkg.sv
// rtl/tts_pkg.sv - shared widths and FSM state type for the HPB write controller
package tts_pkg;
  localparam int HPB_ADDR_W        = 14;
  localparam int HPB_RAM_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hpb_wr_state_e;
endpackage

// File: rtl/hpb_fifo.sv
// rtl/hpb_fifo.sv - command FIFO with wrap-bit binary pointers
// Head, empty and full are decoded only from registered pointers and storage.
module hpb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/hpb_wr_ctl.sv
// rtl/hpb_wr_ctl.sv - buffers host writes and hands them one at a time to the RAM control block
// Each write is REQ until done, then one REL cycle with req low so downstream re-arms.
module hpb_wr_ctl
  import tts_pkg::*;
#(
  parameter int HPB_RAM_WIDTH  = HPB_RAM_WIDTH_DEF,
  parameter int HPB_FIFO_DEPTH = 4,
  parameter int HPB_STALL_CYC  = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       host_wr_valid,
  input  logic [HPB_ADDR_W-1:0]      host_wr_addr,
  input  logic [HPB_RAM_WIDTH-1:0]   host_wr_data,
  input  logic [HPB_RAM_WIDTH/8-1:0] host_wr_be,
  output logic                       host_wr_ready,
  input  logic                       host_stall_clr,
  output logic [HPB_ADDR_W-1:0]      hpb_wr_addr,
  output logic [HPB_RAM_WIDTH-1:0]   hpb_wr_data,
  output logic [HPB_RAM_WIDTH/8-1:0] hpb_wr_en,
  output logic                       hpb_wr_req,
  input  logic                       rcb_wr_done,
  output logic                       hpb_busy,
  output logic                       hpb_stall,
  output logic [15:0]                hpb_wr_count
);
  localparam int          BE_W        = HPB_RAM_WIDTH / 8;
  localparam int          ENTRY_W     = HPB_ADDR_W + HPB_RAM_WIDTH + BE_W;
  localparam logic [15:0] STALL_LIMIT = 16'(HPB_STALL_CYC);

  hpb_wr_state_e          state_q, state_d;
  logic [HPB_ADDR_W-1:0]  addr_q, addr_d;
  logic [HPB_RAM_WIDTH-1:0] data_q, data_d;
  logic [BE_W-1:0]        be_q, be_d;
  logic [15:0]            stall_cnt_q, stall_cnt_d;
  logic                   stall_q, stall_d, stall_set;
  logic [15:0]            count_q, count_d;

  logic                   fifo_pop, fifo_empty, fifo_full;
  logic [ENTRY_W-1:0]     fifo_head;

  hpb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (HPB_FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (host_wr_valid),
    .push_data_i ({host_wr_addr, host_wr_data, host_wr_be}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign host_wr_ready = !fifo_full;
  assign fifo_pop      = (state_q == REQ) && rcb_wr_done;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    be_d        = be_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = REQ;
      REQ:     if (rcb_wr_done) state_d = REL;
      REL:     state_d = fifo_empty ? IDLE : REQ;
      default: state_d = IDLE;
    endcase

    // Latch the head on entry so the RAM side sees it stable for the whole request.
    if (state_d == REQ && state_q != REQ) begin
      {addr_d, data_d, be_d} = fifo_head;
      stall_cnt_d            = 16'd1;
    end else if (state_d == REQ && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    stall_set = (state_d == REQ) && (stall_cnt_d == STALL_LIMIT);
    stall_d   = stall_set ? 1'b1 : (host_stall_clr ? 1'b0 : stall_q);
    count_d   = fifo_pop ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      be_q        <= be_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
      count_q     <= count_d;
    end
  end

  assign hpb_wr_req   = (state_q == REQ);
  assign hpb_wr_addr  = addr_q;
  assign hpb_wr_data  = data_q;
  assign hpb_wr_en    = be_q;
  assign hpb_busy     = !fifo_empty || (state_q != IDLE);
  assign hpb_stall    = stall_q;
  assign hpb_wr_count = count_q;
endmodule
